alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1, is the number of cycles operands are held on the ALU before capture; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  in  1 each  requester k has an operation pending.
REQ-005 req0_ready / req1_ready  out  1 each  requester k's operation is accepted this cycle.
REQ-006 req0_code / req1_code  in  3 each  opcode: 001 XOR, 010 ADD, 011 AND, 100 SUB.
REQ-007 req0_a, req0_b / req1_a, req1_b  in  4 each  operands.
REQ-008 alu_code  out  3, alu_a  out  4, alu_b  out  4  drive to the shared ALU.
REQ-009 alu_out  in  4, alu_carry  in  1, alu_sign  in  1, alu_zero  in  1  combinational ALU results.
REQ-010 rsp_valid  out  1, rsp_ready  in  1  response handshake.
REQ-011 rsp_id  out  1  requester index of the response.
REQ-012 rsp_result  out  4, rsp_flags  out  3 {carry,sign,zero}, rsp_err  out  1  response payload.
REQ-013 ops_count  out  8  count of completed legal operations.

Function
REQ-014 FSM states: IDLE, ISSUE, RESP.
REQ-015 reqk_ready is high only in IDLE and only for the granted requester; a transfer is reqk_valid && reqk_ready at a rising edge.
REQ-016 Round-robin grant: a single valid requester is granted; with both valid, the requester not served last is granted; last_grant toggles only on a transfer.
REQ-017 On transfer, requester id, code, a and b are latched internally; requester inputs are ignored until the FSM returns to IDLE.
REQ-018 Legal code on transfer: IDLE->ISSUE; alu_code/alu_a/alu_b drive the latched values, stable for all HOLD_CYCLES cycles of ISSUE.
REQ-019 Capture edge = HOLD_CYCLES rising edges after the transfer edge: alu_out->rsp_result, {alu_carry,alu_sign,alu_zero}->rsp_flags, rsp_err=0; ISSUE->RESP. Flags are passed through as presented, never recomputed.
REQ-020 Illegal code (000, 101-111) on transfer: IDLE->RESP directly; ALU never driven; rsp_result=0, rsp_flags=000, rsp_err=1; ops_count unchanged.
REQ-021 Outside ISSUE, alu_code=000, alu_a=0, alu_b=0.
REQ-022 rsp_valid is high exactly in RESP; rsp_id/result/flags/err stay stable while rsp_valid && !rsp_ready.
REQ-023 rsp_valid && rsp_ready at an edge: RESP->IDLE; if the response was legal, ops_count increments (8-bit, 255 wraps to 0).
REQ-024 No new request is accepted in the cycle the response is consumed; the earliest next transfer is the following edge (max one op in flight).
REQ-025 HOLD_CYCLES=0 behaves as 1; the internal hold counter is 4 bits.

Reset
REQ-026 While rst_n=0, immediately: state=IDLE, req0_ready=req1_ready=0 until the first edge after deassertion, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=000, rsp_err=0, ops_count=0, alu_* =0, last_grant=1 (requester 0 wins the first tie).
REQ-027 Reset asserted in ISSUE or RESP aborts the operation with no response, no count update, and no ALU drive thereafter.

Verification
REQ-028 HOLD=1; req0 ADD a=8 b=8; ALU returns out=0000 carry=1 sign=0 zero=0 -> rsp_valid one edge after transfer, rsp_id=0, result=0000, flags=100, err=0, ops_count=1 after consumption.
REQ-029 req1 SUB a=3 b=7; ALU returns 0100 sign=1 -> rsp_id=1, result=0100, flags=010.
REQ-030 Both requesters valid continuously for 4 ops, rsp_ready=1 after reset -> grant order 0,1,0,1; no back-to-back accept edges.
REQ-031 req0 code=110 -> rsp_err=1, result=0, flags=000, alu_code stays 000 throughout, ops_count unchanged.
REQ-032 HOLD=3, rsp_ready=0 for 5 cycles -> ALU inputs stable for 3 cycles, payload frozen while stalled, reqk_ready=0 throughout.
REQ-033 rst_n pulsed low in mid-ISSUE -> all outputs at reset values within the same cycle; no response is emitted; the next tie grants requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
//
// Purpose: grants one of two requesters per operation (round-robin on ties).
// It latches the granted opcode and operands and drives them onto the shared
// ALU for HOLD_CYCLES cycles. It then captures the ALU result and flags and
// returns them through a valid/ready response channel. Illegal opcodes are
// answered directly with an error response and never reach the ALU.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqK_valid/ready              requester K handshake (K = 0, 1)
//   reqK_code/a/b                 requester K opcode (3b) and operands (4b)
//   alu_code/a/b                  drive to the shared ALU (zero when not issuing)
//   alu_out/carry/sign/zero       combinational ALU results
//   rsp_valid/ready               response handshake
//   rsp_id/result/flags/err       response payload, flags = {carry,sign,zero}
//   ops_count                     completed legal operations (wraps at 256)
module alu_arbiter #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_code,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_code,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic [2:0] alu_code,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_out,
    input  logic       alu_carry,
    input  logic       alu_sign,
    input  logic       alu_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic [2:0] rsp_flags,
    output logic       rsp_err,
    output logic [7:0] ops_count
);

    // A hold of zero is treated as one cycle.
    localparam logic [3:0] HOLD_EFF = (HOLD_CYCLES <= 0) ? 4'd1 : 4'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       armed;        // low until the first edge after reset release
    logic       last_grant;   // requester served most recently
    logic       grant;
    logic       xfer;
    logic       legal;
    logic       hold_done;
    logic [2:0] sel_code;
    logic [2:0] lat_code;
    logic [3:0] lat_a;
    logic [3:0] lat_b;
    logic [3:0] hold_cnt;

    // On a tie, the requester not served last wins; otherwise the lone valid one.
    assign grant    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign sel_code = grant ? req1_code : req0_code;
    assign legal    = (sel_code != 3'd0) && (sel_code <= 3'd4);

    assign req0_ready = (state == IDLE) && armed && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && armed && req1_valid && grant;
    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign hold_done = (hold_cnt == HOLD_EFF - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        alu_code  = 3'd0;
        alu_a     = 4'd0;
        alu_b     = 4'd0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_nxt = legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                alu_code = lat_code;
                alu_a    = lat_a;
                alu_b    = lat_b;
                if (hold_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b0;
            last_grant <= 1'b1;
            lat_code   <= 3'd0;
            lat_a      <= 4'd0;
            lat_b      <= 4'd0;
            hold_cnt   <= 4'd0;
            rsp_id     <= 1'b0;
            rsp_result <= 4'd0;
            rsp_flags  <= 3'd0;
            rsp_err    <= 1'b0;
            ops_count  <= 8'd0;
        end else begin
            armed <= 1'b1;
            if (xfer) begin
                last_grant <= grant;
                rsp_id     <= grant;
                lat_code   <= sel_code;
                lat_a      <= grant ? req1_a : req0_a;
                lat_b      <= grant ? req1_b : req0_b;
                hold_cnt   <= 4'd0;
                if (!legal) begin
                    rsp_result <= 4'd0;
                    rsp_flags  <= 3'd0;
                    rsp_err    <= 1'b1;
                end
            end
            if (state == ISSUE) begin
                if (hold_done) begin
                    rsp_result <= alu_out;
                    rsp_flags  <= {alu_carry, alu_sign, alu_zero};
                    rsp_err    <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt + 4'd1;
                end
            end
            if ((state == RESP) && rsp_ready && !rsp_err) begin
                ops_count <= ops_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard testbench for alu_arbiter with an ALU stub
module tb_alu_arbiter;

    localparam int HOLD = 3;

    typedef struct packed {
        logic       id;
        logic [3:0] res;
        logic [2:0] fl;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r_valid [2];
    logic [2:0] r_code  [2];
    logic [3:0] r_a     [2];
    logic [3:0] r_b     [2];
    logic [6:0] r_nz    [2];
    logic       rsp_ready;

    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0] req0_code, req1_code, alu_code;
    logic [3:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out;
    logic       alu_carry, alu_sign, alu_zero;
    logic       rsp_valid, rsp_id, rsp_err;
    logic [3:0] rsp_result;
    logic [2:0] rsp_flags;
    logic [7:0] ops_count;

    assign req0_valid = r_valid[0];
    assign req0_code  = r_code[0];
    assign req0_a     = r_a[0];
    assign req0_b     = r_b[0];
    assign req1_valid = r_valid[1];
    assign req1_code  = r_code[1];
    assign req1_a     = r_a[1];
    assign req1_b     = r_b[1];

    int checks = 0;
    int passes = 0;

    exp_t       q[$];
    logic       inflight = 1'b0;
    logic       cur_legal = 1'b0;
    logic [2:0] cur_code = 3'd0;
    logic [3:0] cur_a = 4'd0;
    logic [3:0] cur_b = 4'd0;
    logic [6:0] cur_nz = 7'd0;
    logic       last_m = 1'b1;
    logic [7:0] count_m = 8'd0;
    logic       seen_first = 1'b0;
    logic       armed_m;
    int         alu_cyc = 0;
    int         exp_cyc = 0;
    int         cyc = 0;

    alu_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_code(req0_code),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_code(req1_code),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .ops_count(ops_count)
    );

    always #5 clk = ~clk;

    // Plain arithmetic model of the ALU: {result, carry, sign, zero}.
    function automatic logic [6:0] alu_ref(input logic [2:0] c, input logic [3:0] a,
                                           input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        logic       cy;
        s  = 5'd0;
        r  = 4'd0;
        cy = 1'b0;
        case (c)
            3'd1: r = a ^ b;
            3'd2: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; cy = s[4]; end
            3'd3: r = a & b;
            3'd4: begin r = a - b; cy = (a < b); end
            default: r = 4'd0;
        endcase
        return {r, cy, r[3], (r == 4'd0)};
    endfunction

    // ALU stub; the per-operation noise makes its flags differ from any recomputation.
    assign {alu_out, alu_carry, alu_sign, alu_zero} =
        (alu_code == 3'd0) ? 7'h5B : (alu_ref(alu_code, alu_a, alu_b) ^ cur_nz);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed_m <= 1'b0;
        else armed_m <= 1'b1;
        cyc <= cyc + 1;
    end

    // Monitor and scoreboard.
    always @(negedge clk) begin
        logic x0, x1, eg, k;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            inflight = 1'b0;
            last_m   = 1'b1;
            count_m  = 8'd0;
        end else begin
            x0 = req0_valid && req0_ready;
            x1 = req1_valid && req1_ready;
            if (inflight || !armed_m) begin
                chk("ready_blocked", 32'({req1_ready, req0_ready}), 32'd0);
            end else if (req0_valid || req1_valid) begin
                eg = (req0_valid && req1_valid) ? ~last_m : req1_valid;
                chk("grant", 32'({x1, x0}), eg ? 32'd2 : 32'd1);
            end

            if (inflight && cur_legal && !rsp_valid) begin
                chk("alu_drive", 32'({alu_code, alu_a, alu_b}), 32'({cur_code, cur_a, cur_b}));
                alu_cyc++;
            end else begin
                chk("alu_idle", 32'({alu_code, alu_a, alu_b}), 32'd0);
            end

            chk("ops_count", 32'(ops_count), 32'(count_m));
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    if (!seen_first) begin
                        chk("latency", cyc, exp_cyc);
                        seen_first = 1'b1;
                    end
                    chk("payload", 32'({rsp_id, rsp_result, rsp_flags, rsp_err}), 32'(q[0]));
                    if (rsp_ready) begin
                        chk("hold_cycles", alu_cyc, cur_legal ? HOLD : 0);
                        if (!q[0].err) count_m = count_m + 8'd1;
                        void'(q.pop_front());
                        inflight = 1'b0;
                    end
                end
            end else if (inflight && cyc >= exp_cyc) begin
                chk("late_rsp", 32'(rsp_valid), 32'd1);
            end

            if (x0 || x1) begin
                k         = x1;
                cur_code  = r_code[k];
                cur_a     = r_a[k];
                cur_b     = r_b[k];
                cur_nz    = r_nz[k];
                cur_legal = (cur_code >= 3'd1) && (cur_code <= 3'd4);
                e.id      = k;
                if (cur_legal) begin
                    {e.res, e.fl} = alu_ref(cur_code, cur_a, cur_b) ^ cur_nz;
                    e.err = 1'b0;
                end else begin
                    e.res = 4'd0;
                    e.fl  = 3'd0;
                    e.err = 1'b1;
                end
                q.push_back(e);
                inflight   = 1'b1;
                alu_cyc    = 0;
                seen_first = 1'b0;
                exp_cyc    = cyc + 1 + (cur_legal ? HOLD : 0);
                last_m     = k;
            end
        end
    end

    task automatic new_op(input int k, input int pill);
        if ($urandom_range(99) < pill) begin
            case ($urandom_range(3))
                0: r_code[k] = 3'd0;
                1: r_code[k] = 3'd5;
                2: r_code[k] = 3'd6;
                default: r_code[k] = 3'd7;
            endcase
        end else begin
            r_code[k] = 3'($urandom_range(4, 1));
        end
        r_a[k]  = 4'($urandom);
        r_b[k]  = 4'($urandom);
        r_nz[k] = 7'($urandom);
    endtask

    task automatic send(input int k, input logic [2:0] c, input logic [3:0] a,
                        input logic [3:0] b, input logic [6:0] nz);
        logic done;
        done = 1'b0;
        @(posedge clk); #1;
        r_code[k] = c; r_a[k] = a; r_b[k] = b; r_nz[k] = nz; r_valid[k] = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (k == 0) done = req0_ready;
            else done = req1_ready;
        end
        if (!done) chk("send_timeout", 32'(done), 32'd1);
        @(posedge clk); #1;
        r_valid[k] = 1'b0;
    endtask

    task automatic run_random(input int n, input int pv, input int pr, input int pill);
        logic acc [2];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            acc[0] = req0_valid && req0_ready;
            acc[1] = req1_valid && req1_ready;
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (!r_valid[k] || acc[k]) begin
                    r_valid[k] = ($urandom_range(99) < pv);
                    new_op(k, pill);
                end
            end
            rsp_ready = ($urandom_range(99) < pr);
        end
        @(posedge clk); #1;
        r_valid[0] = 1'b0;
        r_valid[1] = 1'b0;
        rsp_ready  = 1'b1;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = !inflight && (q.size() == 0) && !rsp_valid;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_ops_count", 32'(ops_count), 32'd0);
        chk("rst_alu", 32'({alu_code, alu_a, alu_b}), 32'd0);
    endtask

    initial begin
        logic [1:0] w;
        logic       got;
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            r_valid[k] = 1'b0; r_code[k] = 3'd2; r_a[k] = 4'd1; r_b[k] = 4'd1; r_nz[k] = 7'd0;
        end
        r_valid[0] = 1'b1;
        #12;
        check_reset_outputs();
        r_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;

        // ADD 8+8: ALU presents 0000 with flags 100.
        send(0, 3'd2, 4'd8, 4'd8, 7'b0000_001);
        wait_idle();
        chk("ops_after_add", 32'(ops_count), 32'd1);
        // SUB 3-7: ALU presents 0100 with flags 010.
        send(1, 3'd4, 4'd3, 4'd7, 7'b1000_100);
        wait_idle();
        // Illegal opcode: error response, no ALU drive, no count.
        send(0, 3'd6, 4'd5, 4'd9, 7'd0);
        wait_idle();
        chk("ops_after_illegal", 32'(ops_count), 32'd2);
        // Stalled response: payload must stay frozen.
        rsp_ready = 1'b0;
        send(1, 3'd1, 4'd12, 4'd10, 7'b0101_011);
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle();

        // Both requesters valid continuously: strict alternation.
        run_random(40, 100, 100, 0);
        wait_idle();
        // General random traffic including illegal codes and stalls.
        run_random(3000, 60, 70, 20);
        wait_idle();

        // Reset in mid-ISSUE, then a tie must go to requester 0.
        send(0, 3'd3, 4'd15, 4'd6, 7'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        r_valid[0] = 1'b1; r_code[0] = 3'd1;
        r_valid[1] = 1'b1; r_code[1] = 3'd2;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        got = 1'b0;
        w   = 2'b00;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            w = {req1_valid && req1_ready, req0_valid && req0_ready};
            if (w != 2'b00) got = 1'b1;
        end
        chk("tie_after_reset", 32'(w), 32'd1);
        @(posedge clk); #1;
        r_valid[0] = 1'b0;
        r_valid[1] = 1'b0;
        wait_idle();
        chk("ops_after_reset", 32'(ops_count), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
